// File: rtl/adc5g_cal_pkg.sv
// adc5g_cal_pkg: shared FSM state encoding and ramp constants for the tap calibrator.
package adc5g_cal_pkg;

    typedef enum logic [3:0] {
        IDLE, RST, SETTLE, DWELL, EVAL, STEP, CENTER, MOVE, FAILST, FINISH
    } cal_state_t;

    localparam int RAMP_INC = 1;

endpackage

// File: rtl/adc5g_tap_cal_ctrl_g2b.sv
// adc5g_gray2bin: parameterised Gray-to-binary converter.
module adc5g_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/adc5g_tap_cal_ctrl.sv
// adc5g_tap_cal_ctrl: sweeps the lane delay over all taps, checks the Gray test ramp
// at each tap and parks the delay at the centre of the longest clean window.
module adc5g_tap_cal_ctrl
    import adc5g_cal_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int TAP_BITS   = 5,
    parameter int DWELL_LOG2 = 8,
    parameter int SETTLE_CYC = 16,
    parameter int MIN_EYE    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_WIDTH-1:0] gc_data,
    input  logic                gc_valid,
    output logic                dly_rst,
    output logic                dly_inc,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [TAP_BITS-1:0] tap_sel,
    output logic [TAP_BITS-1:0] eye_start,
    output logic [TAP_BITS:0]   eye_len
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX = '1;

    cal_state_t              state;
    logic [SW-1:0]           settle_cnt;
    logic [DWELL_LOG2-1:0]   dwell_cnt;
    logic [DATA_WIDTH-1:0]   prev;
    logic [DATA_WIDTH-1:0]   bin;
    logic                    err;
    logic                    ramp_bad;
    logic [TAP_BITS:0]       run;
    logic [TAP_BITS:0]       best;
    logic [TAP_BITS-1:0]     best_start;
    logic [TAP_BITS-1:0]     target;
    logic                    mv_armed;

    adc5g_gray2bin #(.W(DATA_WIDTH)) u_g2b (
        .gray (gc_data),
        .bin  (bin)
    );

    assign ramp_bad = bin != (prev + DATA_WIDTH'(RAMP_INC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dly_rst    <= 1'b0;
            dly_inc    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            tap_sel    <= '0;
            eye_start  <= '0;
            eye_len    <= '0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            prev       <= '0;
            err        <= 1'b0;
            run        <= '0;
            best       <= '0;
            best_start <= '0;
            target     <= '0;
            mv_armed   <= 1'b0;
        end else begin
            dly_rst <= 1'b0;
            dly_inc <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    fail  <= 1'b0;
                    state <= RST;
                end
                RST: begin
                    dly_rst    <= 1'b1;
                    tap_sel    <= '0;
                    run        <= '0;
                    best       <= '0;
                    best_start <= '0;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    dwell_cnt  <= '0;
                    err        <= 1'b0;
                    if (settle_cnt == SW'(SETTLE_CYC - 1)) state <= DWELL;
                end
                // first valid sample of a dwell only seeds prev
                DWELL: if (gc_valid) begin
                    prev      <= bin;
                    dwell_cnt <= dwell_cnt + 1'b1;
                    if (dwell_cnt != '0 && ramp_bad) err <= 1'b1;
                    if (dwell_cnt == '1) state <= EVAL;
                end
                EVAL: begin
                    run <= err ? '0 : run + 1'b1;
                    if (!err && run + 1'b1 > best) begin
                        best       <= run + 1'b1;
                        best_start <= tap_sel - run[TAP_BITS-1:0];
                    end
                    state <= (tap_sel == TAP_MAX) ? CENTER : STEP;
                end
                STEP: begin
                    dly_inc    <= 1'b1;
                    tap_sel    <= tap_sel + 1'b1;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                CENTER: begin
                    target   <= best_start + best[TAP_BITS:1];
                    mv_armed <= 1'b0;
                    state    <= (best < (TAP_BITS+1)'(MIN_EYE)) ? FAILST : MOVE;
                end
                MOVE: begin
                    if (!mv_armed) begin
                        dly_rst  <= 1'b1;
                        tap_sel  <= '0;
                        mv_armed <= 1'b1;
                    end else if (tap_sel != target) begin
                        dly_inc <= 1'b1;
                        tap_sel <= tap_sel + 1'b1;
                    end else begin
                        state <= FINISH;
                    end
                end
                FAILST: begin
                    dly_rst <= 1'b1;
                    tap_sel <= '0;
                    fail    <= 1'b1;
                    state   <= FINISH;
                end
                FINISH: begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    eye_start <= best_start;
                    eye_len   <= best;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
